execute_wb_ctrl: RTL and testbench

EXECUTE_WB_CTRL -- requirements
Module: execute_wb_ctrl

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_mul_timer.sv | 28 ++
 rtl/execute_wb_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_execute_wb_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared constants for the execute/write-back controller:
// unit one-hot codes, FSM state encoding and default MUL latency.
package exec_pkg;

  localparam int MUL_LAT_DEF = 3;

  localparam logic [2:0] U_AU  = 3'b001;
  localparam logic [2:0] U_MUL = 3'b010;
  localparam logic [2:0] U_LSU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LSU_REQ,
    S_LSU_WAIT,
    S_MUL_WAIT
  } state_t;

  // Anything that is not exactly MUL or LSU runs on the AU.
  function automatic logic is_mul(input logic [2:0] u);
    return u == U_MUL;
  endfunction

  function automatic logic is_lsu(input logic [2:0] u);
    return u == U_LSU;
  endfunction

endpackage

// File: rtl/exec_mul_timer.sv
// Shared multiplier latency counter: load, decrement-to-zero, zero flag.
// Ports: clk, rst_n (sync, active low), i_load/i_load_val, i_dec, o_zero.
module exec_mul_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/execute_wb_ctrl.sv
// Execute -> write-back controller for a dual-issue bundle (AU/MUL/LSU).
// Ports: issue bundle in, LSU handshake, MUL starts, stall, WB enables.
module execute_wb_ctrl
  import exec_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       issue_valid,
  input  logic       reg_write1_execute,
  input  logic       reg_write2_execute,
  input  logic [4:0] rd1_execute,
  input  logic [4:0] rd2_execute,
  input  logic [2:0] au_mul_lsu1,
  input  logic [2:0] au_mul_lsu2,
  input  logic       lsu_ready,
  input  logic       lsu_done,
  output logic       stall,
  output logic       mul_start1,
  output logic       mul_start2,
  output logic       lsu_req,
  output logic       lsu_slot,
  output logic       wb_valid,
  output logic       reg_write1_wb_en,
  output logic       reg_write2_wb_en,
  output logic       busy,
  output logic       err_dual_lsu
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  state_t r_state;
  state_t w_next;

  logic       r_rw1;
  logic       r_rw2;
  logic [4:0] r_rd1;
  logic [4:0] r_rd2;
  logic       r_has_mul;
  logic       r_has_lsu;
  logic       r_slot;
  logic       r_dual;
  logic       r_lsu_ok;
  logic       r_err;

  logic       w_idle;
  logic       w_iss;
  logic       w_mul1;
  logic       w_mul2;
  logic       w_lsu1;
  logic       w_lsu2;
  logic       w_in_mul;
  logic       w_in_lsu;
  logic       w_in_dual;
  logic       w_zero;
  logic       w_lsu_ok;
  logic       w_finish;
  logic       w_wb;
  logic       w_rw1;
  logic       w_rw2;
  logic [4:0] w_rd1;
  logic [4:0] w_rd2;
  logic       w_dual;
  logic       w_en1;
  logic       w_en2;

  assign w_idle    = (r_state == S_IDLE);
  assign w_iss     = w_idle && issue_valid;
  assign w_mul1    = is_mul(au_mul_lsu1);
  assign w_mul2    = is_mul(au_mul_lsu2);
  assign w_lsu1    = is_lsu(au_mul_lsu1);
  assign w_lsu2    = is_lsu(au_mul_lsu2);
  assign w_in_mul  = w_mul1 || w_mul2;
  assign w_in_lsu  = w_lsu1 || w_lsu2;
  assign w_in_dual = w_lsu1 && w_lsu2;

  // A done pulse completes the LSU in the same cycle it arrives.
  assign w_lsu_ok = r_lsu_ok ||
                    (r_state == S_LSU_WAIT && lsu_done);

  assign w_finish = !w_idle &&
                    (w_lsu_ok || !r_has_lsu) &&
                    (w_zero || !r_has_mul);

  exec_mul_timer #(
    .W (4)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_iss && w_in_mul),
    .i_load_val (MUL_LOAD),
    .i_dec      (!w_idle),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (issue_valid && w_in_lsu) begin
          w_next = lsu_ready ? S_LSU_WAIT : S_LSU_REQ;
        end else if (issue_valid && w_in_mul) begin
          w_next = S_MUL_WAIT;
        end
      end
      S_LSU_REQ: begin
        if (lsu_ready) w_next = S_LSU_WAIT;
      end
      S_LSU_WAIT: begin
        if (w_finish) w_next = S_IDLE;
        else if (w_lsu_ok) w_next = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (w_finish) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rw1     <= 1'b0;
      r_rw2     <= 1'b0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_has_mul <= 1'b0;
      r_has_lsu <= 1'b0;
      r_slot    <= 1'b0;
      r_dual    <= 1'b0;
    end else if (w_iss) begin
      r_rw1     <= reg_write1_execute;
      r_rw2     <= reg_write2_execute;
      r_rd1     <= rd1_execute;
      r_rd2     <= rd2_execute;
      r_has_mul <= w_in_mul;
      r_has_lsu <= w_in_lsu;
      r_slot    <= !w_lsu1;
      r_dual    <= w_in_dual;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lsu_ok <= 1'b0;
    end else if (w_finish) begin
      r_lsu_ok <= 1'b0;
    end else if (r_state == S_LSU_WAIT && lsu_done) begin
      r_lsu_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_iss && w_in_dual) begin
      r_err <= 1'b1;
    end
  end

  // Single-cycle AU bundles retire straight from the issue inputs.
  assign w_wb = (w_iss && !w_in_mul && !w_in_lsu) || w_finish;

  assign w_rw1  = w_idle ? reg_write1_execute : r_rw1;
  assign w_rw2  = w_idle ? reg_write2_execute : r_rw2;
  assign w_rd1  = w_idle ? rd1_execute : r_rd1;
  assign w_rd2  = w_idle ? rd2_execute : r_rd2;
  assign w_dual = w_idle ? w_in_dual : r_dual;

  assign w_en2 = w_wb && w_rw2 && (w_rd2 != '0) && !w_dual;
  // Same destination: the younger slot 2 result wins.
  assign w_en1 = w_wb && w_rw1 && (w_rd1 != '0) &&
                 !(w_en2 && w_rd1 == w_rd2);

  assign stall = rst_n &&
                 ((w_iss && (w_in_mul || w_in_lsu)) ||
                  (!w_idle && !w_finish));

  assign mul_start1 = rst_n && w_iss && w_mul1;
  assign mul_start2 = rst_n && w_iss && w_mul2;

  assign lsu_req = rst_n &&
                   ((w_iss && w_in_lsu) ||
                    r_state == S_LSU_REQ);
  assign lsu_slot = w_idle ? !w_lsu1 : r_slot;

  assign wb_valid         = rst_n && w_wb;
  assign reg_write1_wb_en = rst_n && w_en1;
  assign reg_write2_wb_en = rst_n && w_en2;
  assign busy             = rst_n && !w_idle;
  assign err_dual_lsu     = r_err;

endmodule

// File: tb/tb_execute_wb_ctrl.sv
// Directed bench for execute_wb_ctrl (MUL_LAT = 3).
// Vector table for single-cycle bundles plus multi-cycle sequences.
module tb_execute_wb_ctrl;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic       rw1, rw2;
  logic [4:0] rd1, rd2;
  logic [2:0] u1, u2;
  logic       lsu_ready, lsu_done;
  logic       stall, ms1, ms2, lsu_req, lsu_slot;
  logic       wb_valid, en1, en2, busy, err;

  int n_vec;
  int n_bad;

  execute_wb_ctrl #(.MUL_LAT(3)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .issue_valid        (issue_valid),
    .reg_write1_execute (rw1),
    .reg_write2_execute (rw2),
    .rd1_execute        (rd1),
    .rd2_execute        (rd2),
    .au_mul_lsu1        (u1),
    .au_mul_lsu2        (u2),
    .lsu_ready          (lsu_ready),
    .lsu_done           (lsu_done),
    .stall              (stall),
    .mul_start1         (ms1),
    .mul_start2         (ms2),
    .lsu_req            (lsu_req),
    .lsu_slot           (lsu_slot),
    .wb_valid           (wb_valid),
    .reg_write1_wb_en   (en1),
    .reg_write2_wb_en   (en2),
    .busy               (busy),
    .err_dual_lsu       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv, w1, w2;
    logic [4:0] d1, d2;
    logic [2:0] s1, s2;
    logic       wb, e1, e2;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic w1,
                       input logic w2, input logic [4:0] d1,
                       input logic [4:0] d2, input logic [2:0] s1,
                       input logic [2:0] s2);
    issue_valid = iv;
    rw1 = w1;
    rw2 = w2;
    rd1 = d1;
    rd2 = d2;
    u1  = s1;
    u2  = s2;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 3'b001, 3'b001);
    lsu_ready = 1'b0;
    lsu_done  = 1'b0;
  endtask

  // Settle inputs, then compare mid-cycle.
  task automatic settle();
    #1;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    tbl[0] = '{1,1,1,5'd5,5'd6,3'b001,3'b001,1,1,1};
    tbl[1] = '{1,1,1,5'd7,5'd7,3'b001,3'b001,1,0,1};
    tbl[2] = '{1,1,1,5'd0,5'd0,3'b001,3'b001,1,0,0};
    tbl[3] = '{0,1,1,5'd5,5'd6,3'b001,3'b001,0,0,0};
    tbl[4] = '{1,1,1,5'd3,5'd4,3'b000,3'b000,1,1,1};
    tbl[5] = '{1,1,1,5'd3,5'd4,3'b011,3'b110,1,1,1};
    tbl[6] = '{1,1,0,5'd9,5'd9,3'b111,3'b101,1,1,0};
    tbl[7] = '{1,0,1,5'd0,5'd12,3'b001,3'b001,1,0,1};

    // Reset: outputs forced low even with a valid bundle.
    rst_n = 1'b0;
    idle_in();
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 3'b001, 3'b001);
    next();
    settle();
    chk("rst_wb", wb_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_en1", en1, 1'b0);
    chk("rst_err", err, 1'b0);
    next();
    rst_n = 1'b1;
    idle_in();

    // Single-cycle bundles from the table.
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].w1, tbl[i].w2, tbl[i].d1,
            tbl[i].d2, tbl[i].s1, tbl[i].s2);
      settle();
      chk($sformatf("v%0d_stall", i), stall, 1'b0);
      chk($sformatf("v%0d_wb", i), wb_valid, tbl[i].wb);
      chk($sformatf("v%0d_en1", i), en1, tbl[i].e1);
      chk($sformatf("v%0d_en2", i), en2, tbl[i].e2);
      chk($sformatf("v%0d_ms", i), ms1 | ms2, 1'b0);
      chk($sformatf("v%0d_req", i), lsu_req, 1'b0);
      chk($sformatf("v%0d_busy", i), busy, 1'b0);
      next();
    end

    // MUL slot1 + AU slot2: stall T0..T2, wb at T3.
    drive(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 3'b010, 3'b001);
    settle();
    chk("mul_t0_ms1", ms1, 1'b1);
    chk("mul_t0_ms2", ms2, 1'b0);
    chk("mul_t0_stall", stall, 1'b1);
    chk("mul_t0_wb", wb_valid, 1'b0);
    next();
    idle_in();
    settle();
    chk("mul_t1_ms1", ms1, 1'b0);
    chk("mul_t1_stall", stall, 1'b1);
    chk("mul_t1_busy", busy, 1'b1);
    next();
    settle();
    chk("mul_t2_stall", stall, 1'b1);
    chk("mul_t2_wb", wb_valid, 1'b0);
    next();
    settle();
    chk("mul_t3_stall", stall, 1'b0);
    chk("mul_t3_wb", wb_valid, 1'b1);
    chk("mul_t3_en1", en1, 1'b1);
    chk("mul_t3_en2", en2, 1'b1);
    next();
    settle();
    chk("mul_t4_wb", wb_valid, 1'b0);
    chk("mul_t4_busy", busy, 1'b0);

    // Both slots MUL, same rd: parallel start, slot2 wins.
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 3'b010, 3'b010);
    settle();
    chk("mm_t0_ms1", ms1, 1'b1);
    chk("mm_t0_ms2", ms2, 1'b1);
    next();
    idle_in();
    next();
    settle();
    chk("mm_t2_wb", wb_valid, 1'b0);
    next();
    settle();
    chk("mm_t3_wb", wb_valid, 1'b1);
    chk("mm_t3_en1", en1, 1'b0);
    chk("mm_t3_en2", en2, 1'b1);
    next();

    // LSU slot2, ready low 2 cycles, done 3 cycles after accept.
    drive(1'b1, 1'b1, 1'b1, 5'd2, 5'd8, 3'b001, 3'b100);
    settle();
    chk("lsu_t0_req", lsu_req, 1'b1);
    chk("lsu_t0_slot", lsu_slot, 1'b1);
    chk("lsu_t0_stall", stall, 1'b1);
    next();
    idle_in();
    lsu_done = 1'b1;
    settle();
    chk("lsu_t1_req", lsu_req, 1'b1);
    chk("lsu_t1_slot", lsu_slot, 1'b1);
    chk("lsu_t1_wb", wb_valid, 1'b0);
    next();
    lsu_done  = 1'b0;
    lsu_ready = 1'b1;
    settle();
    chk("lsu_t2_req", lsu_req, 1'b1);
    next();
    lsu_ready = 1'b0;
    settle();
    chk("lsu_t3_req", lsu_req, 1'b0);
    chk("lsu_t3_stall", stall, 1'b1);
    next();
    settle();
    chk("lsu_t4_wb", wb_valid, 1'b0);
    next();
    lsu_done = 1'b1;
    settle();
    chk("lsu_t5_wb", wb_valid, 1'b1);
    chk("lsu_t5_stall", stall, 1'b0);
    chk("lsu_t5_en1", en1, 1'b1);
    chk("lsu_t5_en2", en2, 1'b1);
    next();
    lsu_done = 1'b0;
    settle();
    chk("lsu_t6_busy", busy, 1'b0);

    // MUL slot1 + LSU slot2, done at T1: wb only at T3.
    drive(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 3'b010, 3'b100);
    lsu_ready = 1'b1;
    settle();
    chk("ml_t0_ms1", ms1, 1'b1);
    chk("ml_t0_req", lsu_req, 1'b1);
    chk("ml_t0_slot", lsu_slot, 1'b1);
    next();
    idle_in();
    lsu_done = 1'b1;
    settle();
    chk("ml_t1_wb", wb_valid, 1'b0);
    chk("ml_t1_stall", stall, 1'b1);
    next();
    lsu_done = 1'b0;
    settle();
    chk("ml_t2_wb", wb_valid, 1'b0);
    chk("ml_t2_busy", busy, 1'b1);
    next();
    settle();
    chk("ml_t3_wb", wb_valid, 1'b1);
    chk("ml_t3_stall", stall, 1'b0);
    next();
    settle();
    chk("ml_t4_wb", wb_valid, 1'b0);

    // Dual LSU: slot1 only, sticky error, slot2 write dropped.
    drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd11, 3'b100, 3'b100);
    lsu_ready = 1'b1;
    settle();
    chk("dl_t0_slot", lsu_slot, 1'b0);
    chk("dl_t0_req", lsu_req, 1'b1);
    next();
    idle_in();
    lsu_done = 1'b1;
    settle();
    chk("dl_t1_err", err, 1'b1);
    chk("dl_t1_wb", wb_valid, 1'b1);
    chk("dl_t1_en1", en1, 1'b1);
    chk("dl_t1_en2", en2, 1'b0);
    next();
    lsu_done = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 3'b001, 3'b001);
    settle();
    chk("dl_t2_err", err, 1'b1);
    chk("dl_t2_en2", en2, 1'b1);
    next();

    // Reset while waiting on the LSU aborts the bundle.
    drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd11, 3'b100, 3'b100);
    lsu_ready = 1'b1;
    next();
    idle_in();
    settle();
    chk("ab_wait_busy", busy, 1'b1);
    rst_n = 1'b0;
    settle();
    chk("ab_rst_busy", busy, 1'b0);
    chk("ab_rst_wb", wb_valid, 1'b0);
    chk("ab_rst_stall", stall, 1'b0);
    next();
    rst_n    = 1'b1;
    lsu_done = 1'b1;
    settle();
    chk("ab_post_wb", wb_valid, 1'b0);
    chk("ab_post_busy", busy, 1'b0);
    chk("ab_post_err", err, 1'b0);
    chk("ab_post_stall", stall, 1'b0);
    next();
    lsu_done = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
